// File: rtl/rx_sort_buffer.sv
// rx_sort_buffer: gathers DEPTH bytes from the UART receiver, bubble-sorts
// them into ascending unsigned order in place, then hands them one at a time
// to the UART transmitter with a DV/Done handshake.
module rx_sort_buffer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Tx_DV,
  output logic [7:0] o_Tx_Byte,
  input  logic       i_Tx_Done,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_overrun
);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_SORT    = 2'd1,
    S_SEND    = 2'd2,
    S_WAIT    = 2'd3
  } state_t;

  state_t state_r;
  state_t state_nx_s;

  // Buffer is sized to the full counter range so every index is in bounds.
  logic [7:0]       mem_r [0:(2**CNT_W)-1];
  logic [CNT_W-1:0] wr_r;
  logic [CNT_W-1:0] p_r;
  logic [CNT_W-1:0] j_r;
  logic [CNT_W-1:0] k_r;
  logic             swap_r;

  logic [7:0]       a_s;
  logic [7:0]       b_s;
  logic [CNT_W-1:0] j_nx_s;
  logic [CNT_W-1:0] last_j_s;
  logic             gt_s;
  logic             pass_end_s;
  logic             sort_done_s;
  logic             rx_last_s;
  logic             last_k_s;
  logic             frame_end_s;

  // Compare-pair fetch and the terminal-condition decodes shared by FSM and datapath.
  always_comb begin
    j_nx_s      = j_r + CNT_W'(1);
    a_s         = mem_r[j_r];
    b_s         = mem_r[j_nx_s];
    gt_s        = (a_s > b_s);
    last_j_s    = CNT_W'(DEPTH - 2) - p_r;
    pass_end_s  = (j_r >= last_j_s);
    // The sort finishes early once a whole pass (this cycle included) saw no swap.
    sort_done_s = (!(swap_r || gt_s)) || (p_r == CNT_W'(DEPTH - 2));
    rx_last_s   = (wr_r == CNT_W'(DEPTH - 1));
    last_k_s    = (k_r == CNT_W'(DEPTH - 1));
    frame_end_s = (state_r == S_WAIT) && i_Tx_Done && last_k_s;
  end

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_COLLECT: begin
        if (i_Rx_DV && rx_last_s) begin
          state_nx_s = S_SORT;
        end else begin
          state_nx_s = S_COLLECT;
        end
      end
      S_SORT: begin
        if (pass_end_s && sort_done_s) begin
          state_nx_s = S_SEND;
        end else begin
          state_nx_s = S_SORT;
        end
      end
      S_SEND: begin
        state_nx_s = S_WAIT;
      end
      S_WAIT: begin
        if (i_Tx_Done) begin
          if (last_k_s) begin
            state_nx_s = S_COLLECT;
          end else begin
            state_nx_s = S_SEND;
          end
        end else begin
          state_nx_s = S_WAIT;
        end
      end
      default: begin
        state_nx_s = S_COLLECT;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r <= S_COLLECT;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Write, pass, compare and transmit index counters plus the per-pass swap flag.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_r   <= '0;
      p_r    <= '0;
      j_r    <= '0;
      k_r    <= '0;
      swap_r <= 1'b0;
    end else begin
      case (state_r)
        S_COLLECT: begin
          if (i_Rx_DV) begin
            wr_r <= wr_r + CNT_W'(1);
            if (rx_last_s) begin
              p_r    <= '0;
              j_r    <= '0;
              swap_r <= 1'b0;
            end
          end
        end
        S_SORT: begin
          if (!pass_end_s) begin
            j_r <= j_nx_s;
            if (gt_s) begin
              swap_r <= 1'b1;
            end
          end else if (sort_done_s) begin
            k_r <= '0;
          end else begin
            p_r    <= p_r + CNT_W'(1);
            j_r    <= '0;
            swap_r <= 1'b0;
          end
        end
        S_SEND: begin
          k_r <= k_r;
        end
        S_WAIT: begin
          if (i_Tx_Done) begin
            if (last_k_s) begin
              wr_r <= '0;
            end else begin
              k_r <= k_r + CNT_W'(1);
            end
          end
        end
        default: begin
          wr_r <= '0;
        end
      endcase
    end
  end

  // Byte buffer: filled while collecting, swapped in place while sorting.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      if ((state_r == S_COLLECT) && i_Rx_DV) begin
        mem_r[wr_r] <= i_Rx_Byte;
      end else if ((state_r == S_SORT) && gt_s) begin
        mem_r[j_r]    <= b_s;
        mem_r[j_nx_s] <= a_s;
      end
    end
  end

  // Registered outputs: Tx strobe/byte, frame-done pulse, sticky overrun, busy.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_Tx_DV      <= 1'b0;
      o_Tx_Byte    <= 8'h00;
      o_frame_done <= 1'b0;
      o_overrun    <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_Tx_DV      <= (state_r == S_SEND);
      if (state_r == S_SEND) begin
        o_Tx_Byte <= mem_r[k_r];
      end
      o_frame_done <= frame_end_s;
      // Any byte arriving outside S_COLLECT is lost, including on the frame-complete cycle.
      o_overrun    <= o_overrun || (i_Rx_DV && (state_r != S_COLLECT));
      o_busy       <= (state_nx_s != S_COLLECT);
    end
  end

endmodule

// File: tb/tb_rx_sort_buffer.sv
// Bench for rx_sort_buffer: frames are sorted by a queue-based reference,
// expected bytes are queued and a monitor compares every o_Tx_DV byte.
module tb_rx_sort_buffer;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       tx_done = 1'b0;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       busy;
  logic       frame_done;
  logic       overrun;

  rx_sort_buffer #(.DEPTH(DEPTH), .CNT_W(4)) dut (
    .i_clock(clk), .i_reset(rst), .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
    .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte), .i_Tx_Done(tx_done),
    .o_busy(busy), .o_frame_done(frame_done), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         dv_cycles[$];
  int         fd_count = 0;
  bit         resp_en = 1'b1;
  int         done_delay = 10;
  int         kick_cnt = 0;
  int         kick_ack = 0;
  int         rx_last_cyc = 0;
  int         frames_done_exp = 0;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: compare every transmitted byte against the scoreboard, count frame_done pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_dv) begin
        dv_cycles.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got byte %02h, expected no transmission", tx_byte);
        end else begin
          check("tx_byte", int'(tx_byte), int'(exp_q.pop_front()));
        end
      end
      if (frame_done) fd_count++;
    end
  end

  // Transmitter model: returns i_Tx_Done done_delay cycles after each DV, or on request.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_dv && resp_en) begin
        repeat (done_delay) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end else if (kick_cnt != kick_ack) begin
        kick_ack++;
        @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 rx_dv = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1 rx_dv = 1'b0;
  endtask

  // Sends one frame; when expect_out is set the sorted reference is queued.
  task automatic load_frame(input logic [7:0] f [DEPTH], input bit expect_out, input bit inject);
    logic [7:0] s[$];
    foreach (f[i]) s.push_back(f[i]);
    s.sort();
    if (expect_out) begin
      foreach (s[i]) exp_q.push_back(s[i]);
      frames_done_exp++;
    end
    foreach (f[i]) send_byte(f[i]);
    rx_last_cyc = cyc;
    if (inject) begin
      rx_dv = 1'b1;
      rx_byte = 8'hAA;
      @(posedge clk);
      #1 rx_dv = 1'b0;
    end
  endtask

  task automatic wait_frame(input int base_fd);
    int n = 0;
    while (fd_count == base_fd && n < 3000) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("frame_done_seen", fd_count, base_fd + 1);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    check("rst_busy", int'(busy), 0);
    check("rst_tx_dv", int'(tx_dv), 0);
    check("rst_overrun", int'(overrun), 0);
  endtask

  logic [7:0] f1 [DEPTH] = '{8'h05, 8'h03, 8'h08, 8'h01, 8'h09, 8'h02, 8'h07, 8'h04};
  logic [7:0] f2 [DEPTH] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
  logic [7:0] f3 [DEPTH] = '{8'hFF, 8'h00, 8'h7F, 8'h7F, 8'h80, 8'h00, 8'hFF, 8'h01};
  logic [7:0] f4 [DEPTH] = '{8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
  logic [7:0] fr [DEPTH];

  initial begin
    int base;
    int base_fd;
    int n;
    int stable;
    logic [7:0] held;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_tx_dv", int'(tx_dv), 0);
    check("reset_tx_byte", int'(tx_byte), 0);
    check("reset_frame_done", int'(frame_done), 0);
    check("reset_overrun", int'(overrun), 0);
    rst = 1'b0;

    // Basic frame, plus Done-to-DV spacing (done_delay + 2).
    base = dv_cycles.size();
    base_fd = fd_count;
    load_frame(f1, 1'b1, 1'b0);
    wait_frame(base_fd);
    check("overrun_clean", int'(overrun), 0);
    check("done_to_dv", dv_cycles[base + 1] - dv_cycles[base], done_delay + 2);

    // Already-sorted frame: first DV 8 cycles after the last Rx byte.
    base = dv_cycles.size();
    base_fd = fd_count;
    load_frame(f2, 1'b1, 1'b0);
    wait_frame(base_fd);
    check("sorted_latency", dv_cycles[base] - rx_last_cyc, DEPTH);

    // Reverse frame: worst case DEPTH*(DEPTH-1)/2 compare cycles.
    base = dv_cycles.size();
    base_fd = fd_count;
    load_frame(f4, 1'b1, 1'b0);
    wait_frame(base_fd);
    check("reverse_latency", dv_cycles[base] - rx_last_cyc, DEPTH * (DEPTH - 1) / 2 + 1);

    // Duplicates and extremes.
    base_fd = fd_count;
    load_frame(f3, 1'b1, 1'b0);
    wait_frame(base_fd);

    // Overrun: AA injected during sorting is dropped and the flag sticks.
    base_fd = fd_count;
    load_frame(f1, 1'b1, 1'b1);
    wait_frame(base_fd);
    check("overrun_set", int'(overrun), 1);
    for (int i = 0; i < DEPTH; i++) fr[i] = 8'($urandom);
    base_fd = fd_count;
    load_frame(fr, 1'b1, 1'b0);
    wait_frame(base_fd);
    check("overrun_sticky", int'(overrun), 1);

    // Random frames with random Done delays.
    for (int t = 0; t < 4; t++) begin
      done_delay = $urandom_range(1, 6);
      for (int i = 0; i < DEPTH; i++) fr[i] = 8'($urandom_range(0, 255));
      base_fd = fd_count;
      load_frame(fr, 1'b1, 1'b0);
      wait_frame(base_fd);
    end
    done_delay = 10;

    // Reset in the middle of sorting, then a fresh frame.
    load_frame(f4, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    do_reset();
    base_fd = fd_count;
    load_frame(f3, 1'b1, 1'b0);
    wait_frame(base_fd);

    // Reset while waiting for Done, then a fresh frame.
    base = dv_cycles.size();
    load_frame(f1, 1'b1, 1'b0);
    frames_done_exp--;
    n = 0;
    while (dv_cycles.size() < base + 3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("mid_wait_reached", dv_cycles.size() - base, 3);
    do_reset();
    base_fd = fd_count;
    for (int i = 0; i < DEPTH; i++) fr[i] = 8'($urandom);
    load_frame(fr, 1'b1, 1'b0);
    wait_frame(base_fd);

    // Done held off for 1000 cycles: byte stable, DV not repeated.
    resp_en = 1'b0;
    base = dv_cycles.size();
    base_fd = fd_count;
    load_frame(f1, 1'b1, 1'b0);
    n = 0;
    while (dv_cycles.size() == base && n < 1000) begin
      @(negedge clk);
      n++;
    end
    held = tx_byte;
    stable = 1;
    repeat (1000) begin
      @(negedge clk);
      if (tx_byte != held || tx_dv) stable = 0;
    end
    check("hold_stable", stable, 1);
    check("hold_single_dv", dv_cycles.size() - base, 1);
    resp_en = 1'b1;
    kick_cnt++;
    wait_frame(base_fd);

    // Spurious Done while collecting has no effect.
    base = dv_cycles.size();
    base_fd = fd_count;
    kick_cnt++;
    repeat (6) @(negedge clk);
    check("spurious_busy", int'(busy), 0);
    check("spurious_no_dv", dv_cycles.size() - base, 0);
    check("spurious_no_fd", fd_count - base_fd, 0);
    load_frame(f2, 1'b1, 1'b0);
    wait_frame(base_fd);
    check("post_spurious_latency", dv_cycles[base] - rx_last_cyc, DEPTH);

    check("frame_count", fd_count, frames_done_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
